// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a single 32-bit integer ALU.
// Flow: IDLE grants one request, EXEC registers the result, RESP holds it until the consumer takes it.
module alu_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_eq,
  output logic             rsp_cary,
  output logic             rsp_of,
  output logic             rsp_err,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;

  typedef struct packed {
    logic             id;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  logic [1:0] state;
  logic       last_id;
  req_t       cap;
  logic       grant, gnt_id;

  // On contention the requester not served last wins; otherwise whoever is valid.
  assign gnt_id     = (req0_valid & req1_valid) ? ~last_id : req1_valid;
  assign grant      = ~rst & (state == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = grant & ~gnt_id;
  assign req1_ready = grant & gnt_id;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_s;
  logic             alu_eq, alu_c, alu_o, alu_err;

  always_comb begin
    sum     = '0;
    alu_s   = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_err = 1'b0;
    case (cap.op)
      3'b000: begin
        sum   = {1'b0, cap.a} + {1'b0, cap.b};
        alu_s = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_o = (cap.a[WIDTH-1] == cap.b[WIDTH-1]) && (alu_s[WIDTH-1] != cap.a[WIDTH-1]);
      end
      3'b001: begin
        // a + ~b + 1: carry-out is set exactly when no borrow occurs
        sum   = {1'b0, cap.a} + {1'b0, ~cap.b} + {{WIDTH{1'b0}}, 1'b1};
        alu_s = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_o = (cap.a[WIDTH-1] != cap.b[WIDTH-1]) && (alu_s[WIDTH-1] != cap.a[WIDTH-1]);
      end
      3'b010:  alu_s = cap.a & cap.b;
      3'b011:  alu_s = cap.a | cap.b;
      3'b100:  alu_s = cap.a ^ cap.b;
      default: alu_err = 1'b1;
    endcase
    alu_eq = (cap.a == cap.b) & ~alu_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_id  <= 1'b1;
      cap      <= '0;
      rsp_id   <= 1'b0;
      rsp_s    <= '0;
      rsp_eq   <= 1'b0;
      rsp_cary <= 1'b0;
      rsp_of   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          cap     <= '{id: gnt_id,
                       op: gnt_id ? req1_op : req0_op,
                       a:  gnt_id ? req1_a  : req0_a,
                       b:  gnt_id ? req1_b  : req0_b};
          last_id <= gnt_id;
          state   <= EXEC;
        end
        EXEC: begin
          rsp_id   <= cap.id;
          rsp_s    <= alu_s;
          rsp_eq   <= alu_eq;
          rsp_cary <= alu_c;
          rsp_of   <= alu_o;
          rsp_err  <= alu_err;
          state    <= RESP;
        end
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 32-bit integer ALU between two requesters (req0, req1) using round-robin arbitration.
- Accepts one operation per grant with a valid/ready handshake. Computes the result and flags in a registered execute stage. Returns a tagged response on a single shared response channel.
- Sits between the instruction-issue logic and the ALU datapath. Sequences all ALU use so the datapath never sees two operations at once.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  3  requester 0 opcode
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_valid  input  1  requester 1 has an operation pending
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_op  input  3  requester 1 opcode
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- rsp_valid  output  1  response held valid
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester that owns the response (0 or 1)
- rsp_s  output  WIDTH  result
- rsp_eq  output  1  a equals b
- rsp_cary  output  1  carry / no-borrow
- rsp_of  output  1  signed overflow
- rsp_err  output  1  illegal opcode
- busy  output  1  FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Opcodes:
  - 000 ADD
  - 001 SUB (a-b)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101-111 illegal
- Flags:
  - eq = (a==b) for every legal op.
  - ADD: cary = carry-out of bit WIDTH-1; of = signed overflow.
  - SUB: cary = 1 when a>=b unsigned (no borrow); of = signed overflow of a-b.
  - AND/OR/XOR: cary=0, of=0. Flags are always driven, never high-Z.
  - Illegal opcode: rsp_s=0, eq=cary=of=0, rsp_err=1. rsp_err=0 for legal ops.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if either valid is high, grant one requester. The grant drives reqN_ready=1 combinationally in the same cycle. The opcode, operands and id are captured at the clock edge. Next state is EXEC. With no valid, stay in IDLE.
  - EXEC: the ALU result and flags are registered into the rsp_* registers. Next state is RESP.
  - RESP: rsp_valid=1. rsp_* is stable until rsp_ready=1 is sampled, then next state is IDLE.
- Ready rules: reqN_ready is high only in IDLE, and only for the granted requester. At most one ready is high per cycle. Requesters hold valid, op, a and b stable until their ready is seen.
- Arbitration:
  - Register last_id holds the id of the requester served most recently.
  - If both are valid, grant !last_id. If one is valid, grant it.
  - last_id updates on grant.
- Latency and throughput: accept at edge T gives rsp_valid=1 from T+2. With rsp_ready tied high, peak rate is 1 operation per 3 cycles.
- Handshake boundaries:
  - rsp_ready asserted before RESP has no effect.
  - A requester deasserting valid while in EXEC or RESP has no effect on the captured operation.
  - No new operation is accepted until the response completes; there is no buffering beyond one operation.
- Arithmetic: WIDTH-bit two's complement. The result wraps modulo 2^WIDTH.
- Reset:
  - Reset values: state=IDLE, last_id=1 (req0 wins first contention), rsp_valid=0, rsp_id=0, rsp_s=0, rsp_eq=0, rsp_cary=0, rsp_of=0, rsp_err=0, busy=0, both readys 0 during reset.
  - Reset in EXEC or RESP abandons the operation. No response is produced for it.
  - Reset has priority over every other event in the same cycle.

Test Plan:
- Reset, then req0 ADD a=0xFFFFFFFF b=0x00000001 -> req0_ready=1 at T; at T+2 rsp_valid=1, rsp_id=0, s=0x00000000, cary=1, of=0, eq=0.
- req1 SUB a=0x80000000 b=0x00000001 -> s=0x7FFFFFFF, cary=1, of=1, rsp_id=1; SUB a=5 b=5 -> s=0, eq=1, cary=1.
- Both valid every cycle, rsp_ready=1 -> grant order after reset is 0,1,0,1. Readys are never high together. One grant per 3 cycles.
- XOR a=0xF0F0F0F0 b=0xFFFF0000 -> s=0x0F0FF0F0, cary=0, of=0; then op=110 -> s=0, rsp_err=1, flags 0.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, busy=1, no reqN_ready. rsp_ready=1 -> IDLE next cycle, new grant possible that cycle.
- rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, last_id=1. Next contention grants req0.
